// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel divider, x/y counters, sync decode and a registered, blanked RGB/sync output stage.
// Latency: vga_* pins lag the counters by one pixel (CLK_DIV clocks); no backpressure, free-running.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] x_coords,
  output logic [9:0] y_coords,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       vga_hs_n,
  output logic       vga_vs_n,
  output logic       vga_blank_n,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);

  logic [3:0] div_cnt;
  logic       x_last;
  logic       y_last;
  logic       hs_active;
  logic       vs_active;

  // With CLK_DIV=1 div_cnt never leaves 0, so the tick stays high even in reset.
  assign pixel_tick  = (div_cnt == DIV_LAST);
  assign x_last      = (x_coords == X_LAST);
  assign y_last      = (y_coords == Y_LAST);
  assign frame_start = pixel_tick && x_last && y_last;
  assign video_on    = (x_coords < 10'(H_ACTIVE)) && (y_coords < 10'(V_ACTIVE));
  assign hs_active   = (x_coords >= 10'(HS_START)) && (x_coords < 10'(HS_END));
  assign vs_active   = (y_coords >= 10'(VS_START)) && (y_coords < 10'(VS_END));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 4'd0;
    end else if (pixel_tick) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_coords <= 10'd0;
      y_coords <= 10'd0;
    end else if (pixel_tick) begin
      if (x_last) begin
        x_coords <= 10'd0;
        y_coords <= y_last ? 10'd0 : y_coords + 10'd1;
      end else begin
        x_coords <= x_coords + 10'd1;
      end
    end
  end

  // Output stage captures the decode of the counters as they leave (x,y).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 4'd0;
      vga_g       <= 4'd0;
      vga_b       <= 4'd0;
    end else if (pixel_tick) begin
      vga_hs_n    <= !hs_active;
      vga_vs_n    <= !vs_active;
      vga_blank_n <= video_on;
      vga_r       <= video_on ? red_in   : 4'd0;
      vga_g       <= video_on ? green_in : 4'd0;
      vga_b       <= video_on ? blue_in  : 4'd0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing at CLK_DIV=2 over a few lines, plus a shrunk raster at CLK_DIV=1 for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- DUT A: default 640x480 timing, CLK_DIV=2
  logic       a_rst_n;
  logic [3:0] a_red;
  logic [9:0] a_x, a_y;
  logic       a_von, a_tick, a_fs, a_hs, a_vs, a_bl;
  logic [3:0] a_r, a_g, a_b;

  assign a_red = (a_x == 10'd100) ? 4'hF : 4'h0;

  vga_timing_gen u_dut_a (
    .clock(clock), .reset_n(a_rst_n),
    .red_in(a_red), .green_in(4'hF), .blue_in(4'h5),
    .x_coords(a_x), .y_coords(a_y), .video_on(a_von), .pixel_tick(a_tick),
    .frame_start(a_fs), .vga_hs_n(a_hs), .vga_vs_n(a_vs), .vga_blank_n(a_bl),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  // ---------------- DUT B: 16x10 total raster, CLK_DIV=1
  // H: 8 active, fp 2, sync 3 (x=10..12), bp 3. V: 6 active, fp 1, sync 2 (y=7..8), bp 1.
  logic       b_rst_n;
  logic [9:0] b_x, b_y;
  logic       b_von, b_tick, b_fs, b_hs, b_vs, b_bl;
  logic [3:0] b_r, b_g, b_b;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .clock(clock), .reset_n(b_rst_n),
    .red_in(4'hF), .green_in(4'hF), .blue_in(4'hF),
    .x_coords(b_x), .y_coords(b_y), .video_on(b_von), .pixel_tick(b_tick),
    .frame_start(b_fs), .vga_hs_n(b_hs), .vga_vs_n(b_vs), .vga_blank_n(b_bl),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  initial begin
    int hs_fall1, hs_rise1, hs_fall2, r_first, r_cnt, g_cnt, prev_hs;
    int fs_cnt, fs_first, vs_first, vs_cnt, br_cnt, leak_cnt, hs_cnt;

    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clock);

    // ---------- A: reset state
    check("a_rst_x",    a_x,    0);
    check("a_rst_y",    a_y,    0);
    check("a_rst_von",  a_von,  1);
    check("a_rst_tick", a_tick, 0);
    check("a_rst_fs",   a_fs,   0);
    check("a_rst_hs",   a_hs,   1);
    check("a_rst_vs",   a_vs,   1);
    check("a_rst_bl",   a_bl,   0);
    check("a_rst_g",    a_g,    0);

    // ---------- A: release and run two full lines
    a_rst_n  = 1'b1;
    hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1;
    r_first  = -1; r_cnt = 0; g_cnt = 0; prev_hs = 1;
    for (int k = 1; k <= 3300; k++) begin
      step();
      if (k == 1) begin
        check("a_k1_tick", a_tick, 1);
        check("a_k1_x",    a_x,    0);
        check("a_k1_bl",   a_bl,   0);
      end
      if (k == 2) begin
        check("a_k2_tick", a_tick, 0);
        check("a_k2_x",    a_x,    1);
        check("a_k2_bl",   a_bl,   1);
        check("a_k2_g",    a_g,    15);
        check("a_k2_b",    a_b,    5);
      end
      if (k == 4) check("a_k4_x", a_x, 2);
      if (k <= 1600) begin
        if (a_g == 4'hF) g_cnt++;
        if (a_r == 4'hF) begin
          r_cnt++;
          if (r_first < 0) begin
            r_first = k;
            check("a_r_align_x", a_x, 101);
          end
        end
      end
      if (prev_hs == 1 && a_hs == 1'b0) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (prev_hs == 0 && a_hs == 1'b1 && hs_rise1 < 0) hs_rise1 = k;
      prev_hs = a_hs;
    end
    check("a_hs_fall",   hs_fall1, 1314);
    check("a_hs_width",  hs_rise1 - hs_fall1, 192);
    check("a_hs_period", hs_fall2 - hs_fall1, 1600);
    check("a_r_first",   r_first, 202);
    check("a_r_count",   r_cnt, 2);
    check("a_g_active",  g_cnt, 1280);
    check("a_y_line2",   a_y, 2);
    check("a_vs_hold",   a_vs, 1);

    // ---------- A: async reset mid-line at x=300
    a_rst_n = 1'b0;
    @(negedge clock);
    a_rst_n = 1'b1;
    repeat (600) step();
    check("a_pre_x",  a_x,  300);
    check("a_pre_bl", a_bl, 1);
    a_rst_n = 1'b0;
    #1;
    check("a_arst_x",    a_x,    0);
    check("a_arst_bl",   a_bl,   0);
    check("a_arst_g",    a_g,    0);
    check("a_arst_tick", a_tick, 0);
    @(negedge clock);
    a_rst_n = 1'b1;
    repeat (2) step();
    check("a_restart_x",  a_x,  1);
    check("a_restart_bl", a_bl, 1);
    a_rst_n = 1'b0;

    // ---------- B: reset state with CLK_DIV=1
    @(negedge clock);
    check("b_rst_tick", b_tick, 1);
    check("b_rst_x",    b_x,    0);
    check("b_rst_fs",   b_fs,   0);
    check("b_rst_bl",   b_bl,   0);
    check("b_rst_r",    b_r,    0);
    check("b_rst_von",  b_von,  1);

    // ---------- B: two whole frames (160 clocks each)
    b_rst_n  = 1'b1;
    fs_cnt = 0; fs_first = -1; vs_first = -1; vs_cnt = 0;
    br_cnt = 0; leak_cnt = 0; hs_cnt = 0;
    for (int k = 1; k <= 320; k++) begin
      step();
      if (k == 17) begin
        check("b_k17_x", b_x, 1);
        check("b_k17_y", b_y, 1);
      end
      if (k == 200) check("b_tick_high", b_tick, 1);
      if (b_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
      if (b_bl == 1'b0 && b_r != 4'h0) leak_cnt++;
      if (k <= 160) begin
        if (b_vs == 1'b0) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
        if (b_r == 4'hF) br_cnt++;
      end
      if (k <= 16 && b_hs == 1'b0) hs_cnt++;
    end
    check("b_fs_first",  fs_first, 159);
    check("b_fs_count",  fs_cnt,   2);
    check("b_vs_first",  vs_first, 113);
    check("b_vs_width",  vs_cnt,   32);
    check("b_r_active",  br_cnt,   48);
    check("b_blank_leak", leak_cnt, 0);
    check("b_hs_width",  hs_cnt,   3);

    // ---------- B: async reset mid-frame while hsync is low
    b_rst_n = 1'b0;
    @(negedge clock);
    b_rst_n = 1'b1;
    repeat (60) step();
    check("b_pre_x",  b_x,  12);
    check("b_pre_y",  b_y,  3);
    check("b_pre_hs", b_hs, 0);
    b_rst_n = 1'b0;
    #1;
    check("b_arst_hs",   b_hs,   1);
    check("b_arst_x",    b_x,    0);
    check("b_arst_y",    b_y,    0);
    check("b_arst_tick", b_tick, 1);
    check("b_arst_bl",   b_bl,   0);
    @(negedge clock);
    b_rst_n = 1'b1;
    repeat (17) step();
    check("b_restart_x", b_x, 1);
    check("b_restart_y", b_y, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
